// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential radix-2 signed multiplier.
// Optional early termination is selected with SEQ_MULT_EARLY_TERM_EN.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   // Bit counter must hold indices 0..w-1.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/seq_mult_ctrl_binary_pp.sv
// Binary partial-product generator: selects sign-extended y or zero.
// PIPE=0 is combinational; PIPE!=0 adds one register stage.
module binary_pp #(
   parameter int W    = 16,
   parameter int PIPE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] y,
   input  logic         binary_bit,
   output logic [W:0]   pp
);

   logic [W:0] pp_c;

   assign pp_c = binary_bit ? {y[W-1], y} : '0;

   generate
      if (PIPE == 0) begin : g_comb
         assign pp = pp_c;
      end else begin : g_reg
         logic [W:0] pp_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pp_q <= '0;
            else        pp_q <= pp_c;
         end
         assign pp = pp_q;
      end
   endgenerate

endmodule

// File: rtl/seq_mult_ctrl.sv
// Iterative radix-2 signed multiplier sequencer, one multiplier bit per cycle.
// Define SEQ_MULT_EARLY_TERM_EN to stop once the remaining multiplier bits are 0.
module seq_mult_ctrl
   import mult_pkg::*;
#(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_x,
   input  logic [W-1:0]   in_y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_p,
   output logic           busy
);

   localparam int CW = cnt_width(W);
   localparam int PW = prod_width(W);

   seq_state_e state, state_nx;

   logic [CW-1:0] count;
   logic [W-1:0]  x_q, y_q;
   logic [PW-1:0] acc, acc_nx, pp_sh;
   logic [W:0]    pp;
   logic          accept, release_p, last, finish;

   assign accept    = in_valid & in_ready;
   assign release_p = out_valid & out_ready;
   assign last      = (count == CW'(W - 1));

`ifdef SEQ_MULT_EARLY_TERM_EN
   logic [W-1:0] rest;
   assign rest   = x_q >> count;
   assign finish = last | (rest[W-1:1] == '0);
`else
   assign finish = last;
`endif

   binary_pp #(
      .W    (W),
      .PIPE (0)
   ) u_pp (
      .clk        (clk),
      .rst_n      (rst_n),
      .y          (y_q),
      .binary_bit (x_q[count]),
      .pp         (pp)
   );

   // The MSB carries negative weight, so its partial product is subtracted.
   assign pp_sh  = {{(PW - W - 1){pp[W]}}, pp} << count;
   assign acc_nx = last ? (acc - pp_sh) : (acc + pp_sh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept)    state_nx = RUN;
         RUN:  if (finish)    state_nx = DONE;
         DONE: if (release_p) state_nx = IDLE;
         default:             state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: in_ready = 1'b1;
         RUN:  busy = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '0;
         y_q   <= '0;
         acc   <= '0;
         count <= '0;
         out_p <= '0;
      end else if (accept) begin
         x_q   <= in_x;
         y_q   <= in_y;
         acc   <= '0;
         count <= '0;
      end else if (state == RUN) begin
         acc   <= acc_nx;
         count <= count + 1'b1;
         if (finish) out_p <= acc_nx;
      end
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Randomized self-checking bench for seq_mult_ctrl at W=8.
// Latency expectations follow SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_mult_ctrl;

   localparam int W  = 8;
   localparam int PW = 2 * W;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_x;
   logic [W-1:0]  in_y;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_p;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   seq_mult_ctrl #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
      longint a, b, p;
      a = longint'($signed(x));
      b = longint'($signed(y));
      p = a * b;
      return p[PW-1:0];
   endfunction

   // Number of RUN cycles an operand pair should take.
   function automatic int run_cycles(input logic [W-1:0] x);
`ifdef SEQ_MULT_EARLY_TERM_EN
      int n = 1;
      for (int i = 0; i < W; i++) if (x[i]) n = i + 1;
      return n;
`else
      return W;
`endif
   endfunction

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, input logic [PW-1:0] exp_p);
      int k;
      int cyc;
      logic [PW-1:0] held;
      @(negedge clk);
      in_x = x;
      in_y = y;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("accept_ready", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_x = W'($urandom);
      in_y = W'($urandom);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, run_cycles(x) + 1);
      check("product", out_p, exp_p);
      held = out_p;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1'b1);
         check("hold_p", out_p, held);
         check("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_valid", out_valid, 1'b0);
      check("post_in_ready", in_ready, 1'b1);
   endtask

   task automatic stream(input int nops, input bit b2b);
      logic [PW-1:0] q[$];
      logic [W-1:0]  last_x;
      logic [PW-1:0] e;
      int got = 0;
      int acc_n = 0;
      int cyc = 0;
      int last_acc = -1;
      in_x = W'($urandom);
      in_y = W'($urandom);
      while (got < nops && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (b2b) begin
            in_valid  = (acc_n < nops);
            out_ready = 1'b1;
         end else begin
            in_valid  = (acc_n < nops) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
         end
         if (!(in_ready && in_valid)) begin
            in_x = W'($urandom);
            in_y = W'($urandom);
            if ($urandom_range(0, 7) == 0) in_x = W'($urandom_range(0, 3));
         end else begin
            q.push_back(ref_mul(in_x, in_y));
            if (b2b && last_acc >= 0)
               check("b2b_gap", cyc - last_acc, run_cycles(last_x) + 2);
            last_acc = cyc;
            last_x   = in_x;
            acc_n++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_result", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               check(b2b ? "b2b_product" : "rand_product", out_p, e);
            end
            got++;
         end
      end
      check("results_count", got, nops);
      check("queue_empty", q.size(), 0);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_x      = '0;
      in_y      = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_p", out_p, 0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;

      do_op(8'd3, 8'd5, 0, 16'd15);
      do_op(8'h80, 8'h80, 0, 16'h4000);
      do_op(8'hFF, 8'h7F, 0, 16'hFF81);
      do_op(8'h7F, 8'h80, 5, ref_mul(8'h7F, 8'h80));
      do_op(8'd0, 8'd77, 0, 16'd0);
      do_op(8'd1, 8'hFD, 0, 16'hFFFD);
      do_op(8'd25, 8'd0, 0, 16'd0);

      // Abort an operation mid-run with count at 4.
      @(negedge clk);
      in_x = 8'd7;
      in_y = 8'd9;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_out_p", out_p, 0);
      check("abort_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_result", seen, 1'b0);
      do_op(8'd2, 8'd2, 0, 16'd4);

      stream(20, 1'b1);
      stream(1000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
